// File: rtl/spi_master_pkg.sv
// Shared definitions for the memory-mapped SPI master: bus direction macros,
// register indices, CTRL/STAT bit positions and FSM state encodings.
`ifndef SPI_MASTER_BUS_MACROS
`define SPI_MASTER_BUS_MACROS
`define READ    1'b1
`define WRITE   1'b0
`define ENABLE_ 1'b0
`endif

package spi_master_pkg;

   localparam int SPI_DATA_W = 8;

   // Word register indices (s_addr[1:0])
   localparam logic [1:0] SPI_ADDR_CTRL = 2'd0;
   localparam logic [1:0] SPI_ADDR_DIV  = 2'd1;
   localparam logic [1:0] SPI_ADDR_TX   = 2'd2;
   localparam logic [1:0] SPI_ADDR_RX   = 2'd3;

   // CTRL bits (read/write)
   localparam int CTRL_EN     = 0;
   localparam int CTRL_CPOL   = 1;
   localparam int CTRL_CPHA   = 2;
   localparam int CTRL_IRQ_EN = 3;
   localparam int CTRL_SS     = 4;
   localparam int CTRL_FLUSH  = 5;

   // STAT bits (read-only) and write-1-to-clear flags
   localparam int STAT_BUSY     = 8;
   localparam int STAT_TX_FULL  = 9;
   localparam int STAT_TX_EMPTY = 10;
   localparam int STAT_RX_VALID = 11;
   localparam int STAT_RX_OVR   = 12;
   localparam int STAT_DONE     = 13;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Persistent CTRL fields, packed so the struct lines up with CTRL[4:0]
   typedef struct packed {
      logic ss;
      logic irq_en;
      logic cpha;
      logic cpol;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/spi_master_tx_fifo.sv
// Small synchronous TX FIFO. Head data is read combinationally so the shifter
// can load the byte on the same edge that pops it.
module spi_tx_fifo
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 8,
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [PTR_W:0]    count
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              do_pop;
   logic              do_push;

   assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A pop frees a slot first, so a push into a full FIFO is accepted when
   // it coincides with a pop.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer and occupancy tracking; flush discards everything queued
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Storage array; contents are meaningless while count is 0, so no reset
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master on bus slave slot s5: CTRL/STAT, DIV, TXDATA and
// RXDATA registers, a TX FIFO, and a byte shifter supporting all four modes.
module spi_master
   import spi_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   output logic        irq,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   ctrl_t                 ctrl;
   logic [DIV_W-1:0]      div;
   logic                  busy;
   logic                  done;
   logic                  rx_ovr;
   logic                  rx_valid;
   logic [SPI_DATA_W-1:0] rx_byte;

   logic [1:0]            state;
   logic [DIV_W-1:0]      hcnt;
   logic [3:0]            edge_cnt;
   logic [SPI_DATA_W-1:0] tx_sh;
   logic [SPI_DATA_W-1:0] rx_sh;

   logic [SPI_DATA_W-1:0] fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

   logic                  access;
   logic                  wr_ctrl;
   logic                  wr_div;
   logic                  wr_tx;
   logic                  rd_acc;
   logic                  rx_read;
   logic                  start;
   logic                  done_evt;
   logic                  leading;
   logic                  cfg_lock;
   logic [31:0]           rd_mux;
   logic                  unused_wr_bits;

   assign access   = ~cs_ & ~as_;
   assign rd_acc   = access & (rw == `READ);
   assign wr_ctrl  = access & (rw == `WRITE) & (addr == SPI_ADDR_CTRL);
   assign wr_div   = access & (rw == `WRITE) & (addr == SPI_ADDR_DIV);
   assign wr_tx    = access & (rw == `WRITE) & (addr == SPI_ADDR_TX);
   assign rx_read  = rd_acc & (addr == SPI_ADDR_RX);

   assign start    = (state == ST_IDLE) & ctrl.en & (fifo_count != '0);
   assign done_evt = (state == ST_DONE);
   assign leading  = ~edge_cnt[0];
   // The start edge already commits the shifter to the current mode, so the
   // mode/divisor are frozen there as well as while busy.
   assign cfg_lock = busy | start;

   assign spi_cs_  = ~ctrl.ss;

   assign unused_wr_bits = ^{wr_data[31:14], wr_data[11:8]};

   spi_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (SPI_DATA_W)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_tx),
      .push_data (wr_data[SPI_DATA_W-1:0]),
      .pop       (start),
      .flush     (wr_ctrl & wr_data[CTRL_FLUSH]),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Register read multiplexer
   always_comb begin
      rd_mux = '0;
      case (addr)
         SPI_ADDR_CTRL: rd_mux = {18'b0, done, rx_ovr, rx_valid, fifo_empty,
                                  fifo_full, busy, 3'b0, ctrl};
         SPI_ADDR_DIV:  rd_mux[DIV_W-1:0] = div;
         SPI_ADDR_RX:   rd_mux = {23'b0, rx_valid, rx_byte};
         default:       rd_mux = '0;
      endcase
   end

   // Bus acknowledge and read data, valid in the cycle after the strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_    <= ~`ENABLE_;
         rd_data <= '0;
      end else begin
         rdy_    <= access ? `ENABLE_ : ~`ENABLE_;
         rd_data <= rd_acc ? rd_mux : '0;
      end
   end

   // Software configuration: mode and divisor are locked during a transfer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl <= '0;
         div  <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl.en     <= wr_data[CTRL_EN];
            ctrl.irq_en <= wr_data[CTRL_IRQ_EN];
            ctrl.ss     <= wr_data[CTRL_SS];
            if (!cfg_lock) begin
               ctrl.cpol <= wr_data[CTRL_CPOL];
               ctrl.cpha <= wr_data[CTRL_CPHA];
            end
         end
         if (wr_div && !cfg_lock) div <= wr_data[DIV_W-1:0];
      end
   end

   // Receive holding register and status flags; a set always beats a clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         done     <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (done_evt) begin
            rx_byte  <= rx_sh;
            rx_valid <= 1'b1;
         end else if (rx_read) begin
            rx_valid <= 1'b0;
         end

         if (done_evt && rx_valid && !rx_read) rx_ovr <= 1'b1;
         else if (wr_ctrl && wr_data[STAT_RX_OVR]) rx_ovr <= 1'b0;

         if (done_evt) done <= 1'b1;
         else if (wr_ctrl && wr_data[STAT_DONE]) done <= 1'b0;

         irq <= ctrl.irq_en & (done | rx_ovr);
      end
   end

   // Transfer FSM and byte shifter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         hcnt     <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               spi_sclk <= ctrl.cpol;
               if (start) begin
                  state    <= ST_SHIFT;
                  busy     <= 1'b1;
                  tx_sh    <= fifo_head;
                  hcnt     <= div;
                  edge_cnt <= '0;
                  // cpha=0 presents the MSB before the first SCLK edge
                  if (!ctrl.cpha) spi_mosi <= fifo_head[SPI_DATA_W-1];
               end
            end
            ST_SHIFT: begin
               if (hcnt == '0) begin
                  hcnt     <= div;
                  spi_sclk <= ~spi_sclk;
                  edge_cnt <= edge_cnt + 4'd1;
                  if (leading ^ ctrl.cpha) begin
                     rx_sh <= {rx_sh[SPI_DATA_W-2:0], spi_miso};
                  end else if (ctrl.cpha) begin
                     spi_mosi <= tx_sh[SPI_DATA_W-1];
                     tx_sh    <= {tx_sh[SPI_DATA_W-2:0], 1'b0};
                  end else begin
                     spi_mosi <= tx_sh[SPI_DATA_W-2];
                     tx_sh    <= {tx_sh[SPI_DATA_W-2:0], 1'b0};
                  end
                  if (edge_cnt == 4'd15) state <= ST_DONE;
               end else begin
                  hcnt <= hcnt - DIV_W'(1);
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               spi_sclk <= ctrl.cpol;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: bus register accesses plus an SPI-side
// monitor that checks each shifted byte against a scoreboard queue.
module tb_spi_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cs_ = 1'b1;
   logic        as_ = 1'b1;
   logic        rw = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] rd_data;
   logic        rdy_;
   logic        irq;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_cs_;

   logic        loop_en = 1'b1;
   logic        miso_drv = 1'b0;
   logic [7:0]  miso_pat = 8'h00;
   logic        tb_cpha = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q [$];

   int          cyc = 0;
   int          toggles = 0;
   int          mon_edges = 0;
   logic [7:0]  mon_byte = 8'h00;
   int          t_prev = 0;
   int          t_last_end = 0;
   bit          chk_gap = 1'b0;
   int          gap_base = 0;
   int          exp_half = 2;
   int          exp_gap = 4;

   assign spi_miso = loop_en ? spi_mosi : miso_drv;

   spi_master #(.FIFO_DEPTH(4), .DIV_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .cs_      (cs_),
      .as_      (as_),
      .rw       (rw),
      .addr     (addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .rdy_     (rdy_),
      .irq      (irq),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_cs_  (spi_cs_)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // SPI-side monitor: counts edges while the device is selected, plays the
   // slave for MISO when not looped back, and scores each completed byte.
   always @(spi_sclk or negedge reset) begin
      if (!reset) begin
         mon_edges = 0;
         exp_q.delete();
      end else if (!spi_cs_) begin
         if (mon_edges == 0) begin
            if (chk_gap && toggles != gap_base) check("byte_gap", cyc - t_last_end, exp_gap);
         end else if (mon_edges == 1) begin
            check("half_period", cyc - t_prev, exp_half);
         end
         t_prev = cyc;
         if ((mon_edges % 2) == int'(tb_cpha)) mon_byte = {mon_byte[6:0], spi_mosi};
         if (tb_cpha && (mon_edges % 2 == 0) && !loop_en) miso_drv = miso_pat[7 - mon_edges / 2];
         mon_edges++;
         toggles++;
         if (mon_edges == 16) begin
            mon_edges = 0;
            t_last_end = cyc;
            check("tx_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               $display("spi byte mosi=0x%02h expected=0x%02h", mon_byte, e);
               check("mosi_byte", mon_byte, e);
            end
         end
      end
   end

   task automatic bus(input logic w_rw, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic r);
      @(negedge clk);
      cs_ = 1'b0; as_ = 1'b0; rw = w_rw; addr = a; wr_data = d;
      @(posedge clk);
      #1;
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = 32'd0;
      q = rd_data;
      r = rdy_;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] q;
      logic r;
      bus(1'b0, a, d, q, r);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] q);
      logic r;
      bus(1'b1, a, 32'd0, q, r);
   endtask

   // Poll STAT until done=1, tx_empty=1, busy=0 (bounded)
   task automatic wait_idle(input string tag);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < 300; i++) begin
         rd(2'd0, s);
         if (s[13] && s[10] && !s[8]) break;
      end
      check(tag, {29'd0, s[13], s[10], s[8]}, 32'b110);
   endtask

   initial begin
      logic [31:0] q;
      logic r;
      int model_cnt;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_cs", spi_cs_, 1);
      check("rst_sclk", spi_sclk, 0);
      check("rst_irq", irq, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_rdy_idle", rdy_, 1);
      check("rst_rd_data", rd_data, 0);
      bus(1'b1, 2'd0, 32'd0, q, r);
      check("rst_stat", q, 32'h0000_0400);
      check("rst_rdy_ack", r, 0);
      @(posedge clk);
      #1;
      check("rst_rdy_release", rdy_, 1);
      check("rst_rd_data_release", rd_data, 0);

      // ---- mode 0, DIV=1, loopback ----
      wr(2'd1, 32'd1);
      rd(2'd1, q);
      check("div_read", q, 1);
      exp_half = 2;
      wr(2'd0, 32'h11);
      exp_q.push_back(8'hA5);
      wr(2'd2, 32'hA5);
      wait_idle("m0_idle");
      rd(2'd3, q);
      check("m0_rxdata", q, 32'h1A5);
      rd(2'd2, q);
      check("txdata_read", q, 0);
      check("m0_irq_masked", irq, 0);
      wr(2'd0, 32'h19);
      repeat (2) @(posedge clk);
      #1;
      check("m0_irq", irq, 1);
      rd(2'd0, q);
      check("m0_stat", q, 32'h2419);
      wr(2'd0, 32'h2019);
      repeat (2) @(posedge clk);
      #1;
      check("m0_irq_clear", irq, 0);

      // ---- mode 3, slave drives 0xC3 ----
      wr(2'd0, 32'h06);
      tb_cpha = 1'b1;
      loop_en = 1'b0;
      miso_pat = 8'hC3;
      repeat (2) @(posedge clk);
      #1;
      check("m3_sclk_idle", spi_sclk, 1);
      wr(2'd0, 32'h17);
      exp_q.push_back(8'h3C);
      wr(2'd2, 32'h3C);
      wait_idle("m3_idle");
      rd(2'd3, q);
      check("m3_rxdata", q, 32'h1C3);
      check("m3_sclk_after", spi_sclk, 1);
      wr(2'd0, 32'h2006);
      wr(2'd0, 32'h00);
      tb_cpha = 1'b0;
      loop_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("m0_sclk_idle", spi_sclk, 0);

      // ---- FIFO full with en=0, then drain back to back ----
      wr(2'd0, 32'h10);
      model_cnt = 0;
      for (int v = 1; v <= 5; v++) begin
         if (model_cnt < 4) begin
            exp_q.push_back(8'(v));
            model_cnt++;
         end
         wr(2'd2, 32'(v));
         if (v == 4) begin
            rd(2'd0, q);
            check("fifo_full_4", q[9], 1);
         end
      end
      rd(2'd0, q);
      check("fifo_stat_5", {29'd0, q[10:8]}, 32'b010);
      // Gap from last SCLK edge of one byte to the first of the next:
      // DONE cycle + IDLE start cycle + (DIV+1) cycles to the first edge.
      exp_gap = 1 + 3;
      gap_base = toggles;
      chk_gap = 1'b1;
      wr(2'd0, 32'h11);
      wait_idle("fifo_idle");
      chk_gap = 1'b0;

      // ---- overrun from unread transfers ----
      rd(2'd0, q);
      check("ovr_flags", {29'd0, q[13:11]}, 32'b111);
      rd(2'd3, q);
      check("ovr_rxdata", q, 32'h104);
      wr(2'd0, 32'h1011);
      rd(2'd0, q);
      check("ovr_cleared", {29'd0, q[13:11]}, 32'b100);

      // ---- W1C of done coinciding with DONE: set wins ----
      gap_base = toggles;
      exp_q.push_back(8'h77);
      wr(2'd2, 32'h77);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (toggles - gap_base >= 16) break;
      end
      check("coll_edges", toggles - gap_base, 16);
      cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd0; wr_data = 32'h2011;
      @(posedge clk);
      #1;
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = 32'd0;
      rd(2'd0, q);
      check("coll_done_kept", q[13], 1);
      rd(2'd3, q);
      check("coll_rxdata", q, 32'h177);

      // ---- reset in the middle of a transfer ----
      wr(2'd0, 32'h19);
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_irq", irq, 1);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h6B);
      wr(2'd2, 32'h5A);
      wr(2'd2, 32'h6B);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (mon_edges >= 7) break;
      end
      check("pre_rst_edges", mon_edges, 7);
      check("pre_rst_sclk", spi_sclk, 1);
      check("pre_rst_mosi", spi_mosi, 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_sclk", spi_sclk, 0);
      check("arst_mosi", spi_mosi, 0);
      check("arst_cs", spi_cs_, 1);
      check("arst_irq", irq, 0);
      check("arst_rdy", rdy_, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      rd(2'd0, q);
      check("post_rst_stat", q, 32'h0000_0400);
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_irq", irq, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
